// File: rtl/arith_pkg.sv
// Shared definitions for the multi-cycle arithmetic unit:
// aluOp encodings, control FSM states and op classification.
package arith_pkg;

    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_SLT   = 4'b1010;
    localparam logic [3:0] OP_SLTU  = 4'b1011;
    localparam logic [3:0] OP_MULT  = 4'b0100;
    localparam logic [3:0] OP_MULTU = 4'b0101;
    localparam logic [3:0] OP_DIV   = 4'b0110;
    localparam logic [3:0] OP_DIVU  = 4'b0111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    // 0100..0111 are exactly the multiply/divide codes:
    // bit1 selects divide, bit0 selects unsigned.
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b01;
    endfunction

endpackage

// File: rtl/arith_iter_muldiv.sv
// Iterative multiply/divide engine: one shift-add or restoring step
// per cycle on operand magnitudes, with sign fix-up on the outputs.
// Ports: clk, reset_n, i_start, i_div, i_uns, i_a, i_b in;
//        o_busy, o_done (last step this cycle), o_lo, o_hi, o_dz out.
module arith_iter_muldiv #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_start,
    input  logic             i_div,
    input  logic             i_uns,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_lo,
    output logic [WIDTH-1:0] o_hi,
    output logic             o_dz
);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_m;
    logic [WIDTH-1:0] r_a;
    logic             r_div;
    logic             r_dz;
    logic             r_neg_q;
    logic             r_neg_r;

    logic [WIDTH-1:0]   w_ma;
    logic [WIDTH-1:0]   w_mb;
    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_shl;
    logic [WIDTH:0]     w_diff;
    logic               w_qbit;
    logic [2*WIDTH-1:0] w_prod;
    logic [2*WIDTH-1:0] w_prod_fix;

    assign w_ma = (!i_uns && i_a[WIDTH-1]) ? -i_a : i_a;
    assign w_mb = (!i_uns && i_b[WIDTH-1]) ? -i_b : i_b;

    // multiply: r_lo holds the multiplier, product shifts in from the top
    assign w_sum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);

    // divide: r_hi is the partial remainder, r_lo the dividend/quotient
    assign w_shl  = {r_hi, r_lo[WIDTH-1]};
    assign w_diff = w_shl - {1'b0, r_m};
    assign w_qbit = ~w_diff[WIDTH];

    assign o_busy = r_busy;
    assign o_done = r_busy && (r_cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_m     <= '0;
            r_a     <= '0;
            r_div   <= 1'b0;
            r_dz    <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else if (i_start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_hi    <= '0;
            r_lo    <= i_div ? w_ma : w_mb;
            r_m     <= i_div ? w_mb : w_ma;
            r_a     <= i_a;
            r_div   <= i_div;
            r_dz    <= i_div && (i_b == '0);
            r_neg_q <= !i_uns && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
            r_neg_r <= i_div && !i_uns && i_a[WIDTH-1];
        end else if (r_busy) begin
            r_cnt <= r_cnt + 1'b1;
            if (o_done) begin
                r_busy <= 1'b0;
            end
            if (r_div) begin
                r_hi <= w_qbit ? w_diff[WIDTH-1:0] : w_shl[WIDTH-1:0];
                r_lo <= {r_lo[WIDTH-2:0], w_qbit};
            end else begin
                {r_hi, r_lo} <= {w_sum, r_lo[WIDTH-1:1]};
            end
        end
    end

    assign w_prod     = {r_hi, r_lo};
    assign w_prod_fix = r_neg_q ? -w_prod : w_prod;

    always_comb begin
        o_lo = w_prod_fix[WIDTH-1:0];
        o_hi = w_prod_fix[2*WIDTH-1:WIDTH];
        if (r_dz) begin
            o_lo = '1;
            o_hi = r_a;
        end else if (r_div) begin
            o_lo = r_neg_q ? -r_lo : r_lo;
            o_hi = r_neg_r ? -r_hi : r_hi;
        end
    end

    assign o_dz = r_dz;

endmodule

// File: rtl/arith_unit_mc.sv
// Multi-cycle arithmetic unit: add/sub/slt/sltu in one cycle,
// mult/div through the iterative engine, valid/ready on both sides.
// Ports: clk, reset_n, in_valid, A, B, aluOp, out_ready in;
//        in_ready, out_valid, result_lo, result_hi, overflow, div_zero out.
module arith_unit_mc
    import arith_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       aluOp,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic             overflow,
    output logic             div_zero
);

    state_t r_state;
    state_t w_next;

    logic             r_md;
    logic [WIDTH-1:0] r_lo;
    logic             r_ovf;

    logic             w_accept;
    logic             w_is_md;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_sub;
    logic [WIDTH-1:0] w_simple;
    logic             w_ovf;
    logic             w_md_busy;
    logic             w_md_done;
    logic [WIDTH-1:0] w_md_lo;
    logic [WIDTH-1:0] w_md_hi;
    logic             w_md_dz;

    assign in_ready = reset_n
                   && ((r_state == IDLE)
                   ||  ((r_state == DONE) && out_ready));
    assign w_accept = in_valid && in_ready;
    assign w_is_md  = is_muldiv(aluOp);

    assign w_add = A + B;
    assign w_sub = A - B;

    always_comb begin
        w_simple = w_add;
        w_ovf    = (A[WIDTH-1] == B[WIDTH-1])
                && (w_add[WIDTH-1] != A[WIDTH-1]);
        case (aluOp)
            OP_SUB: begin
                w_simple = w_sub;
                w_ovf    = (A[WIDTH-1] != B[WIDTH-1])
                        && (w_sub[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLT: begin
                w_simple = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
                w_ovf    = 1'b0;
            end
            OP_SLTU: begin
                w_simple = {{(WIDTH-1){1'b0}}, A < B};
                w_ovf    = 1'b0;
            end
            default: ;
        endcase
    end

    arith_iter_muldiv #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_muldiv (
        .clk     (clk),
        .reset_n (reset_n),
        .i_start (w_accept && w_is_md),
        .i_div   (aluOp[1]),
        .i_uns   (aluOp[0]),
        .i_a     (A),
        .i_b     (B),
        .o_busy  (w_md_busy),
        .o_done  (w_md_done),
        .o_lo    (w_md_lo),
        .o_hi    (w_md_hi),
        .o_dz    (w_md_dz)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = w_is_md ? BUSY : DONE;
                end
            end
            BUSY: begin
                if (w_md_done) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (w_accept) begin
                        w_next = w_is_md ? BUSY : DONE;
                    end else begin
                        w_next = IDLE;
                    end
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // Simple ops register their result here; mul/div results stay in
    // the engine and are selected through r_md.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_md  <= 1'b0;
            r_lo  <= '0;
            r_ovf <= 1'b0;
        end else if (w_accept) begin
            r_md  <= w_is_md;
            r_lo  <= w_is_md ? '0 : w_simple;
            r_ovf <= w_is_md ? 1'b0 : w_ovf;
        end
    end

    assign out_valid = (r_state == DONE) && !w_md_busy;
    assign result_lo = r_md ? w_md_lo : r_lo;
    assign result_hi = r_md ? w_md_hi : '0;
    assign overflow  = r_ovf;
    assign div_zero  = r_md && w_md_dz;

endmodule

// File: tb/tb_arith_unit_mc.sv
// Directed vector bench for arith_unit_mc (WIDTH=32): vector table
// plus back-to-back, output stall and mid-operation reset sequences.
module tb_arith_unit_mc;
    import arith_pkg::*;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic [3:0]  aluOp;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic        overflow;
    logic        div_zero;

    int n_cmp = 0;
    int n_bad = 0;

    arith_unit_mc #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .aluOp     (aluOp),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .overflow  (overflow),
        .div_zero  (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] lo;
        logic [31:0] hi;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        @(negedge clk);
        in_valid  = 1'b1;
        A         = v.a;
        B         = v.b;
        aluOp     = v.op;
        out_ready = 1'b1;
        #1;
        check($sformatf("v%0d in_ready", idx), 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        A        = ~v.a;
        B        = 32'h5a5a_1234;
        aluOp    = OP_SUB;
        lat      = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check($sformatf("v%0d latency", idx), 64'(lat), 64'(v.lat));
        check($sformatf("v%0d lo", idx), 64'(result_lo), 64'(v.lo));
        check($sformatf("v%0d hi", idx), 64'(result_hi), 64'(v.hi));
        check($sformatf("v%0d ovf", idx), 64'(overflow), 64'(v.ovf));
        check($sformatf("v%0d dz", idx), 64'(div_zero), 64'(v.dz));
        @(posedge clk);
        #1;
        check($sformatf("v%0d drained", idx), 64'(out_valid), 64'd0);
    endtask

    initial begin
        int cnt;
        logic [31:0] hold;
        vecs[0]  = '{OP_ADD,   32'd5,        32'd3,        32'd8,        32'd0,        1'b0, 1'b0, 1};
        vecs[1]  = '{OP_SUB,   32'h8000_0000, 32'd1,       32'h7FFF_FFFF, 32'd0,       1'b1, 1'b0, 1};
        vecs[2]  = '{OP_SLT,   32'hFFFF_FFFF, 32'd1,       32'd1,        32'd0,        1'b0, 1'b0, 1};
        vecs[3]  = '{OP_SLTU,  32'hFFFF_FFFF, 32'd1,       32'd0,        32'd0,        1'b0, 1'b0, 1};
        vecs[4]  = '{OP_ADD,   32'h7FFF_FFFF, 32'd1,       32'h8000_0000, 32'd0,       1'b1, 1'b0, 1};
        vecs[5]  = '{4'b0001,  32'd10,       32'd20,       32'd30,       32'd0,        1'b0, 1'b0, 1};
        vecs[6]  = '{OP_SUB,   32'd5,        32'd7,        32'hFFFF_FFFE, 32'd0,       1'b0, 1'b0, 1};
        vecs[7]  = '{OP_MULT,  32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[8]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'd2,       32'hFFFF_FFFE, 32'd1,       1'b0, 1'b0, 33};
        vecs[9]  = '{OP_DIV,   32'hFFFF_FFF9, 32'd2,       32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b0, 33};
        vecs[10] = '{OP_DIVU,  32'd7,        32'd0,        32'hFFFF_FFFF, 32'd7,       1'b0, 1'b1, 33};
        vecs[11] = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0,     1'b0, 1'b0, 33};
        vecs[12] = '{OP_DIV,   32'd100,      32'd7,        32'd14,       32'd2,        1'b0, 1'b0, 33};
        vecs[13] = '{OP_MULT,  32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd15,     32'd0,        1'b0, 1'b0, 33};
        vecs[14] = '{OP_DIV,   32'd7,        32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1,       1'b0, 1'b0, 33};
        vecs[15] = '{OP_MULTU, 32'h1234_5678, 32'h10,      32'h2345_6780, 32'd1,       1'b0, 1'b0, 33};
        vecs[16] = '{OP_DIVU,  32'hFFFF_FFFF, 32'd10,      32'h1999_9999, 32'd5,       1'b0, 1'b0, 33};
        vecs[17] = '{OP_DIV,   32'hFFFF_FFF8, 32'd0,       32'hFFFF_FFFF, 32'hFFFF_FFF8, 1'b0, 1'b1, 33};

        reset_n   = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        A         = '0;
        B         = '0;
        aluOp     = OP_ADD;
        #1;
        check("rst in_ready", 64'(in_ready), 64'd0);
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst lo", 64'(result_lo), 64'd0);
        check("rst hi", 64'(result_hi), 64'd0);
        check("rst flags", 64'({overflow, div_zero}), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 18; i++) begin
            run_vec(vecs[i], i);
        end

        // four back-to-back adds, one result per cycle
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            in_valid  = 1'b1;
            out_ready = 1'b1;
            aluOp     = OP_ADD;
            A         = 32'(100 * k + 1);
            B         = 32'(k);
            #1;
            check($sformatf("b2b%0d in_ready", k), 64'(in_ready), 64'd1);
            @(posedge clk);
            #1;
            check($sformatf("b2b%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("b2b%0d lo", k), 64'(result_lo),
                  64'(101 * k + 1));
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("b2b drained", 64'(out_valid), 64'd0);

        // consumer stall: result held, no new accept
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        aluOp     = OP_MULT;
        A         = 32'd6;
        B         = 32'd7;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        aluOp    = OP_ADD;
        A        = 32'd99;
        B        = 32'd1;
        cnt      = 1;
        while (!out_valid && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("stall latency", 64'(cnt), 64'd33);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("stall%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("stall%0d lo", k), 64'(result_lo), 64'd42);
            check($sformatf("stall%0d hi", k), 64'(result_hi), 64'd0);
            check($sformatf("stall%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall release", 64'(out_valid), 64'd0);
        check("stall idle", 64'(in_ready), 64'd1);

        // reset in the middle of a multiply
        @(negedge clk);
        in_valid = 1'b1;
        aluOp    = OP_MULT;
        A        = 32'd3;
        B        = 32'd4;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd0);
        check("midrst lo", 64'(result_lo), 64'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("midrst idle", 64'(in_ready), 64'd1);
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) cnt++;
        end
        check("midrst no result", 64'(cnt), 64'd0);
        hold = 32'd4;
        run_vec('{OP_ADD, 32'd2, 32'd2, hold, 32'd0, 1'b0, 1'b0, 1}, 99);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
